alu_iter: RTL and testbench
===========================

# alu_iter

Iterative execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and executes the selected operation on two operands. It sits in the EX stage. Logic and add/sub/slt operations complete in one cycle. Signed and unsigned multiply run on a radix-2 shift-add engine over WIDTH cycles. A valid/ready handshake on both sides lets the pipeline stall while a multiply is in flight.

## Interface
- WIDTH, 32: operand width; the counter is $clog2(WIDTH)+1 bits wide.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- valid_i  input  1  operation request; ALUCtrl_i, src1_i and src2_i are valid.
- ready_o  output  1  unit can accept a request; high only in IDLE.
- ALUCtrl_i  input  4  operation code; see Operation.
- src1_i  input  WIDTH  operand A (rs).
- src2_i  input  WIDTH  operand B (rt or immediate).
- valid_o  output  1  result valid; held until it is consumed.
- ready_i  input  1  downstream accepts the result.
- result_o  output  WIDTH  result, or the low half of the product.
- result_hi_o  output  WIDTH  high half of the product; 0 for non-multiply ops.
- zero_o  output  1  result is zero. For multiply, the full 2*WIDTH product is checked.
- overflow_o  output  1  signed overflow on ADD or SUB; 0 otherwise.
- illegal_o  output  1  ALUCtrl_i was not a supported code.

## Operation
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A-B)
  - 0111 SLT (signed A<B gives 1, else 0)
  - 1100 MULT (signed)
  - 1101 MULTU (unsigned)
  - Any other code gives result 0, result_hi 0, illegal_o=1, with single-cycle latency.
- State machine:
  - IDLE: ready_o=1.
  - IDLE to DONE: on accept (valid_i&&ready_o) with a single-cycle code. Result and flags are computed from the inputs and registered on the accept edge.
  - IDLE to MUL: on accept with 1100 or 1101.
  - MUL to DONE: after WIDTH iterations.
  - DONE to IDLE: on the edge where valid_o&&ready_i.
- Multiply, accept edge:
  - Load multiplicand and multiplier as magnitudes. For MULT, negative operands are two's-complement negated; for MULTU they are loaded as-is.
  - Record neg = sign(A)^sign(B) for MULT; neg = 0 for MULTU.
  - Clear the 2*WIDTH accumulator and the counter.
- Multiply, each MUL edge:
  - If the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator.
  - Shift the {carry, accumulator} pair right by 1.
  - Increment the counter.
- Multiply, final edge (count==WIDTH-1): if neg, negate the 2*WIDTH product. Register result_hi_o/result_o, zero_o and illegal_o=0.
- Widths:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow_o = (sign A == sign B') && (sign result != sign A), where B' is B for ADD and ~B for SUB.
  - SLT uses the signed comparison and is independent of the SUB overflow.
  - overflow_o is 0 for all other ops, including MULT/MULTU.
- Output registers change only on a transition into DONE, and hold while valid_o=1 and ready_i=0.
- valid_i is ignored whenever ready_o=0. No request is queued.

## Timing
- Reset (rst_i low at a rising edge):
  - State returns to IDLE and the counter clears.
  - valid_o=0 and ready_o=1.
  - result_o, result_hi_o, zero_o, overflow_o and illegal_o all go to 0.
  - An in-flight multiply is discarded and produces no valid_o.
- Single-cycle ops: accept on edge k; valid_o=1 from edge k+1.
- Multiply: accept on edge k; valid_o=1 from edge k+WIDTH+1 (33 cycles for WIDTH=32).
- Throughput: the earliest next accept is the cycle after the consume edge, so the unit adds one bubble per op.
- ready_o is registered (state==IDLE). There is no combinational path from any input to ready_o or valid_o.
- When consume (valid_o&&ready_i) and reset occur on the same edge, reset wins; the result is still treated as consumed.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow_o=1, zero_o=0, valid_o one cycle after accept.
- SUB 0x00001234 - 0x00001234 -> result 0, zero_o=1, overflow_o=0. SLT 0xFFFFFFFE vs 0x00000001 -> result 1.
- MULT 0xFFFFFFFD (-3) x 0x00000005 -> result_hi 0xFFFFFFFF, result_o 0xFFFFFFF1. valid_o exactly 33 cycles after accept; ready_o=0 throughout.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> result_hi 0xFFFFFFFE, result_o 0x00000001. MULT of the same operands -> hi 0, lo 1.
- Backpressure and illegal code:
  - Hold ready_i=0 for 5 cycles after an AND result: outputs stable, valid_o=1, and valid_i pulses in that window are ignored.
  - Code 1010 -> illegal_o=1, result 0.
- Reset mid-multiply: rst_i low at iteration 10 -> next cycle state IDLE, ready_o=1, all outputs 0. A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: iterative EX-stage execution unit.
// Executes AND/OR/ADD/SUB/SLT in one cycle and signed/unsigned multiply on a
// radix-2 shift-add engine over WIDTH cycles. Valid/ready handshakes on both
// sides let the pipeline stall while a multiply is in flight.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   valid_i      request valid (ALUCtrl_i, src1_i, src2_i valid)
//   ready_o      unit idle and able to accept a request
//   ALUCtrl_i    4-bit operation code
//   src1_i       operand A
//   src2_i       operand B
//   valid_o      result valid, held until consumed
//   ready_i      downstream accepts the result
//   result_o     result, or low half of the product
//   result_hi_o  high half of the product (0 for non-multiply ops)
//   zero_o       result (full product for multiply) is zero
//   overflow_o   signed overflow on ADD/SUB
//   illegal_o    unsupported operation code
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             illegal_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpSlt   = 4'b0111;
  localparam logic [3:0] OpMult  = 4'b1100;
  localparam logic [3:0] OpMultu = 4'b1101;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Accumulator: upper half collects partial sums, lower half starts as the
  // multiplier magnitude and is consumed one bit per shift.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;

  // Single-cycle datapath
  logic [WIDTH-1:0]   add_res, sub_res, sc_res;
  logic               sc_ovf, sc_ill;
  logic               is_mul;

  // Multiply datapath
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nxt, prod;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign ready_o     = (state_q == StIdle);
  assign valid_o     = (state_q == StDone);
  assign result_o    = res_q;
  assign result_hi_o = res_hi_q;
  assign zero_o      = zero_q;
  assign overflow_o  = ovf_q;
  assign illegal_o   = ill_q;

  assign is_mul = (ALUCtrl_i == OpMult) || (ALUCtrl_i == OpMultu);

  always_comb begin
    add_res = src1_i + src2_i;
    sub_res = src1_i - src2_i;
    sc_res  = '0;
    sc_ovf  = 1'b0;
    sc_ill  = 1'b0;
    case (ALUCtrl_i)
      OpAnd: sc_res = src1_i & src2_i;
      OpOr:  sc_res = src1_i | src2_i;
      OpAdd: begin
        sc_res = add_res;
        sc_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                 (add_res[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OpSub: begin
        sc_res = sub_res;
        // Subtraction overflows like A + ~B: operand signs differ.
        sc_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                 (sub_res[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OpSlt: sc_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    mag_a = (ALUCtrl_i == OpMult && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    mag_b = (ALUCtrl_i == OpMult && src2_i[WIDTH-1]) ? -src2_i : src2_i;

    mul_sum = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                       : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    prod    = neg_q ? -acc_nxt : acc_nxt;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;

    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          if (is_mul) begin
            mcand_d = mag_a;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            neg_d   = (ALUCtrl_i == OpMult) && (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
            cnt_d   = '0;
            state_d = StMul;
          end else begin
            res_d    = sc_res;
            res_hi_d = '0;
            zero_d   = (sc_res == '0);
            ovf_d    = sc_ovf;
            ill_d    = sc_ill;
            state_d  = StDone;
          end
        end
      end
      StMul: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          res_d    = prod[WIDTH-1:0];
          res_hi_d = prod[2*WIDTH-1:WIDTH];
          zero_d   = (prod == '0);
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_iter;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] result_hi_o;
  logic             zero_o;
  logic             overflow_o;
  logic             illegal_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .ALUCtrl_i  (ALUCtrl_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .result_hi_o(result_hi_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o),
    .illegal_o  (illegal_o)
  );

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        ill;
  } exp_t;

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  // Reference model: true integer arithmetic, then range/bit extraction.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    p  = '0;
    case (c)
      4'b0000: e.lo = a & b;
      4'b0001: e.lo = a | b;
      4'b0010: begin
        s = sa + sb;
        e.lo = s[31:0];
        e.ovf = (s > MaxS) || (s < MinS);
      end
      4'b0110: begin
        s = sa - sb;
        e.lo = s[31:0];
        e.ovf = (s > MaxS) || (s < MinS);
      end
      4'b0111: e.lo = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: begin
        s = sa * sb;
        p = s;
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      4'b1101: begin
        p = {32'd0, a} * {32'd0, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = ({e.hi, e.lo} == 64'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for the result, check it, optionally stall `hold`
  // cycles with ignored valid_i pulses, then consume it.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int hold);
    exp_t        e;
    int          lat, n;
    bit          rdy_low, stable;
    logic [98:0] snap;
    e = model(c, a, b);
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, {63'd0, ready_o}, 64'd1);
    ALUCtrl_i = c;
    src1_i    = a;
    src2_i    = b;
    valid_i   = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    lat     = 1;
    rdy_low = 1'b1;
    while (valid_o !== 1'b1 && lat < 100) begin
      if (ready_o !== 1'b0) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), (c == 4'b1100 || c == 4'b1101) ? 64'(WIDTH + 1) : 64'd1);
    check({tag, " busy"}, {63'd0, rdy_low}, 64'd1);
    check({tag, " lo"}, {32'd0, result_o}, {32'd0, e.lo});
    check({tag, " hi"}, {32'd0, result_hi_o}, {32'd0, e.hi});
    check({tag, " flags"}, {61'd0, zero_o, overflow_o, illegal_o}, {61'd0, e.zero, e.ovf, e.ill});
    if (hold > 0) begin
      snap   = {valid_o, ready_o, result_o, result_hi_o, zero_o, overflow_o, illegal_o};
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        valid_i   = 1'b1;
        ALUCtrl_i = 4'b0010;
        src1_i    = $urandom;
        src2_i    = $urandom;
        @(negedge clk);
        valid_i = 1'b0;
        if ({valid_o, ready_o, result_o, result_hi_o, zero_o, overflow_o, illegal_o} !== snap)
          stable = 1'b0;
      end
      check({tag, " hold stable"}, {63'd0, stable}, 64'd1);
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check({tag, " consumed"}, {62'd0, valid_o, ready_o}, 64'd1);
  endtask

  logic [3:0] codes [8];

  initial begin
    int n;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1010};
    rst_i     = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    ALUCtrl_i = '0;
    src1_i    = '0;
    src2_i    = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    check("reset state", {62'd0, valid_o, ready_o}, 64'd1);
    check("reset outs", {result_hi_o, result_o}, 64'd0);
    check("reset flags", {61'd0, zero_o, overflow_o, illegal_o}, 64'd0);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, "add ovf", 0);
    check("add ovf direct", {32'd0, result_o}, 64'h8000_0000);
    run_op(4'b0110, 32'h0000_1234, 32'h0000_1234, "sub zero", 0);
    run_op(4'b0111, 32'hFFFF_FFFE, 32'h0000_0001, "slt neg", 0);
    run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, "sub ovf", 0);
    run_op(4'b1100, 32'hFFFF_FFFD, 32'h0000_0005, "mult -3x5", 0);
    run_op(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 0);
    run_op(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult -1x-1", 0);
    run_op(4'b1100, 32'h8000_0000, 32'h8000_0000, "mult minint", 0);
    run_op(4'b1100, 32'h0000_0000, 32'h1234_5678, "mult zero", 0);
    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, "and hold", 5);
    run_op(4'b1010, 32'h1111_1111, 32'h2222_2222, "illegal", 0);

    // Reset during multiply iteration 10
    ALUCtrl_i = 4'b1100;
    src1_i    = 32'h0000_1234;
    src2_i    = 32'h0000_5678;
    valid_i   = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    check("midrst state", {62'd0, valid_o, ready_o}, 64'd1);
    check("midrst outs", {result_hi_o, result_o}, 64'd0);
    check("midrst flags", {61'd0, zero_o, overflow_o, illegal_o}, 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) n++;
    end
    check("midrst no valid", 64'(n), 64'd0);
    run_op(4'b0010, 32'd2, 32'd3, "add 2+3", 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      c = codes[$urandom_range(7, 0)];
      if (c == 4'b1010) c = 4'($urandom_range(15, 0));
      a = $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      if (i % 7 == 0) a = {a[31], 31'h7FFF_FFFF};
      run_op(c, a, b, $sformatf("rand%0d op%b", i, c), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
